cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Parameters SHALL be: REG_ADD, 4, opcode/extension/condition field width; PSRL, 5, PSR width.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 OP_CODE, OP_EXT, Rdest_addr  in  REG_ADD each  instruction fields from the datapath; Rdest_addr doubles as the branch condition code.
REQ-005 PSR_OUT  in  PSRL  registered flags, bit order {N,Z,F,L,C} = [4:0].
REQ-006 mem_ready  in  1  memory access completes in the cycle it is high.
REQ-007 PC_S, MEM_DATA_S, SE_SIGN, REG_WR, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, MEM_WE  out  1 each  datapath/memory controls.
REQ-008 MEM_S, WD_S, ALUA_S, ALUB_S  out  2 each  datapath mux selects.
REQ-009 illegal  out  1  one-cycle pulse on an undecoded instruction; state  out  4  current FSM state for debug.

Function
REQ-010 Controller SHALL be a Moore FSM; all outputs decode from the state register plus the instruction fields, and every output not named for a state SHALL be 0.
REQ-011 States SHALL be FETCH, FLOAD, DECODE, EXEC, WB, MEMRD, LDWB, MEMWR, BRANCH, JUMP.
REQ-012 FETCH: MEM_S=01; hold until mem_ready=1, then go to FLOAD.
REQ-013 FLOAD: INSTR_EN=1; PC<=PC+1 via ALUA_S=01, ALUB_S=10, PC_S=1, PC_EN=1; go to DECODE.
REQ-014 DECODE: operand registers load (no enables); next state SHALL be chosen by the decode rules below.
REQ-015 R-type: OP_CODE=0000 with OP_EXT in {0101 ADD, 1001 SUB, 1011 CMP, 0001 AND, 0010 OR, 0011 XOR} -> EXEC with ALUA_S=00, ALUB_S=00.
REQ-016 MOV: OP_CODE=0000, OP_EXT=1101 -> WB with WD_S=01.
REQ-017 I-type: OP_CODE in {0101, 1001, 1011, 0001, 0010, 0011} -> EXEC with ALUA_S=10, ALUB_S=00; SE_SIGN=1 for 0101/1001/1011, else 0.
REQ-018 MOVI: OP_CODE=1101 -> WB with WD_S=00, SE_SIGN=0.
REQ-019 OP_CODE=0100 with OP_EXT=0000 -> MEMRD (LOAD); 0100 -> MEMWR (STOR); 1100 -> JUMP (Jcond).
REQ-020 OP_CODE=1100 -> BRANCH (Bcond).
REQ-021 Any other encoding SHALL pulse illegal for one cycle and return to FETCH, executing as a NOP.
REQ-022 EXEC: ALU_OUT_EN=1, PSR_EN=1, selects held from DECODE; CMP/CMPI -> FETCH, others -> WB with WD_S=11.
REQ-023 WB: REG_WR=1 for exactly one cycle -> FETCH.
REQ-024 MEMRD: MEM_S=00 (address Rsrc); hold until mem_ready, asserting MEM_REG_EN in the ready cycle -> LDWB.
REQ-025 LDWB: WD_S=10, REG_WR=1 -> FETCH.
REQ-026 MEMWR: MEM_S=00, MEM_DATA_S=0, MEM_WE=1; hold until mem_ready -> FETCH; MEM_WE SHALL drop the cycle after the ready cycle.
REQ-027 Condition decode (code->true when): 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1010 !L&!Z; 1011 L|Z; 1100 !N&!Z; 1101 N|Z; 1110 always; 1111 never.
REQ-028 BRANCH, condition true: ALUA_S=01, ALUB_S=01, SE_SIGN=1, PC_S=1, PC_EN=1 (target = incremented PC + displacement); false: no enables; -> FETCH.
REQ-029 JUMP, condition true: PC_S=0, PC_EN=1 (PC<=Rsrc); false: no enables; -> FETCH.
REQ-030 PSR_EN SHALL be asserted only in EXEC; REG_WR only in WB/LDWB; PC_EN only in FLOAD/BRANCH/JUMP.
REQ-031 Latency: ALU op 5 cycles, CMP/branch/jump 4, LOAD 5 and STOR 4 with zero wait states; each low mem_ready cycle SHALL add exactly one cycle.

Reset
REQ-032 reset low SHALL force state=FETCH immediately, with all outputs 0 except MEM_S=01, even mid-instruction, mid-wait or during MEM_WE.
REQ-033 The first rising edge after reset is released SHALL be evaluated in FETCH.

Structure
REQ-034 State encodings, opcode/extension constants, condition codes and PSR bit indices SHALL reside in shared package cpu_pkg.
REQ-035 Condition evaluation SHALL be a single combinational sub-module, cond_check (cond, PSR -> taken).

Verification
REQ-036 Release reset with mem_ready=1 and instruction 0x0251 (ADD) -> FETCH,FLOAD,DECODE,EXEC,WB; REG_WR high 1 cycle; PSR_EN high only in EXEC.
REQ-037 LOAD 0x4301 with mem_ready low for 2 cycles in MEMRD -> MEM_REG_EN only in the ready cycle; LDWB has WD_S=10 and REG_WR=1.
REQ-038 Bcond 0xC0FE with PSR_OUT=5'b01000 -> taken, PC_EN in BRANCH; same with PSR_OUT=0 -> no PC_EN, FETCH next.
REQ-039 CMPI 0xB105 -> PSR_EN=1 in EXEC, no REG_WR, FETCH next (4 cycles).
REQ-040 OP_CODE=1111 -> illegal pulses 1 cycle, no REG_WR/MEM_WE; reset asserted during MEMWR -> MEM_WE falls asynchronously and state=FETCH.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU controller: FSM states, opcode and
// extension fields, branch condition codes, PSR bit positions, decode helpers.
package cpu_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_FLOAD  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_WB     = 4'd4;
  localparam logic [3:0] S_MEMRD  = 4'd5;
  localparam logic [3:0] S_LDWB   = 4'd6;
  localparam logic [3:0] S_MEMWR  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  // ALU extension codes double as the I-type opcodes of the same operation
  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_AND    = 4'b0001;
  localparam logic [3:0] OP_OR     = 4'b0010;
  localparam logic [3:0] OP_XOR    = 4'b0011;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_ADD    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b1001;
  localparam logic [3:0] OP_CMP    = 4'b1011;
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_MOVI   = 4'b1101;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_LO = 4'b0100;
  localparam logic [3:0] COND_NL = 4'b0101;
  localparam logic [3:0] COND_MI = 4'b0110;
  localparam logic [3:0] COND_PL = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_HI = 4'b1010;
  localparam logic [3:0] COND_LS = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_UC = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

  typedef enum logic [3:0] {
    CLS_ALU_R, CLS_ALU_I, CLS_MOV, CLS_MOVI, CLS_LOAD,
    CLS_STOR, CLS_JUMP, CLS_BRANCH, CLS_ILLEGAL
  } instr_class_e;

  function automatic logic is_alu_code(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_CMP) ||
           (code == OP_AND) || (code == OP_OR)  || (code == OP_XOR);
  endfunction

  function automatic logic is_signed_imm(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic instr_class_e decode_class(input logic [3:0] op, input logic [3:0] ext);
    if (op == OP_RTYPE) begin
      if (is_alu_code(ext)) return CLS_ALU_R;
      if (ext == EXT_MOV)   return CLS_MOV;
      return CLS_ILLEGAL;
    end
    if (is_alu_code(op)) return CLS_ALU_I;
    if (op == OP_MOVI)   return CLS_MOVI;
    if (op == OP_BCOND)  return CLS_BRANCH;
    if (op == OP_MEM) begin
      if (ext == EXT_LOAD)  return CLS_LOAD;
      if (ext == EXT_STOR)  return CLS_STOR;
      if (ext == EXT_JCOND) return CLS_JUMP;
    end
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/cond_check.sv
// Branch/jump condition evaluator: maps a 4-bit condition code and the
// registered PSR flags to a taken decision.
module cond_check
  import cpu_pkg::*;
#(
  parameter int REG_ADD = 4,
  parameter int PSRL    = 5
) (
  input  logic [REG_ADD-1:0] cond,
  input  logic [PSRL-1:0]    psr,
  output logic               taken
);

  logic n, z, f, l, c;

  assign n = psr[PSR_N];
  assign z = psr[PSR_Z];
  assign f = psr[PSR_F];
  assign l = psr[PSR_L];
  assign c = psr[PSR_C];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_LO: taken = l;
      COND_NL: taken = !l;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_HI: taken = !l && !z;
      COND_LS: taken = l || z;
      COND_GT: taken = !n && !z;
      COND_LE: taken = n || z;
      COND_UC: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: fetch/decode/execute sequencing with
// memory wait handling, conditional branch and jump, illegal-op trapping.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int REG_ADD = 4,
  parameter int PSRL    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_ADD-1:0] OP_CODE,
  input  logic [REG_ADD-1:0] OP_EXT,
  input  logic [REG_ADD-1:0] Rdest_addr,
  input  logic [PSRL-1:0]    PSR_OUT,
  input  logic               mem_ready,
  output logic               PC_S,
  output logic               MEM_DATA_S,
  output logic               SE_SIGN,
  output logic               REG_WR,
  output logic               INSTR_EN,
  output logic               ALU_OUT_EN,
  output logic               MEM_REG_EN,
  output logic               PC_EN,
  output logic               PSR_EN,
  output logic               MEM_WE,
  output logic [1:0]         MEM_S,
  output logic [1:0]         WD_S,
  output logic [1:0]         ALUA_S,
  output logic [1:0]         ALUB_S,
  output logic               illegal,
  output logic [3:0]         state
);

  instr_class_e cls;
  logic [3:0]   next_state;
  logic         taken;
  logic         is_cmp;
  logic         imm;

  assign cls    = decode_class(OP_CODE, OP_EXT);
  assign imm    = (cls == CLS_ALU_I);
  assign is_cmp = imm ? (OP_CODE == OP_CMP) : (OP_EXT == OP_CMP);

  cond_check #(.REG_ADD(REG_ADD), .PSRL(PSRL)) u_cond (
    .cond  (Rdest_addr),
    .psr   (PSR_OUT),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_FLOAD;
      S_FLOAD:  next_state = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_ALU_R, CLS_ALU_I: next_state = S_EXEC;
          CLS_MOV, CLS_MOVI:    next_state = S_WB;
          CLS_LOAD:             next_state = S_MEMRD;
          CLS_STOR:             next_state = S_MEMWR;
          CLS_JUMP:             next_state = S_JUMP;
          CLS_BRANCH:           next_state = S_BRANCH;
          default:              next_state = S_FETCH;
        endcase
      end
      S_EXEC:   next_state = is_cmp ? S_FETCH : S_WB;
      S_MEMRD:  if (mem_ready) next_state = S_LDWB;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    PC_S = 1'b0; MEM_DATA_S = 1'b0; SE_SIGN = 1'b0; REG_WR = 1'b0;
    INSTR_EN = 1'b0; ALU_OUT_EN = 1'b0; MEM_REG_EN = 1'b0; PC_EN = 1'b0;
    PSR_EN = 1'b0; MEM_WE = 1'b0; illegal = 1'b0;
    MEM_S = 2'b00; WD_S = 2'b00; ALUA_S = 2'b00; ALUB_S = 2'b00;
    case (state)
      S_FETCH: MEM_S = 2'b01;
      S_FLOAD: begin
        INSTR_EN = 1'b1; ALUA_S = 2'b01; ALUB_S = 2'b10;
        PC_S = 1'b1; PC_EN = 1'b1;
      end
      S_DECODE: begin
        case (cls)
          CLS_ALU_I: begin
            ALUA_S  = 2'b10;
            SE_SIGN = is_signed_imm(OP_CODE);
          end
          CLS_MOV:     WD_S = 2'b01;
          CLS_ILLEGAL: illegal = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        ALU_OUT_EN = 1'b1; PSR_EN = 1'b1;
        ALUA_S  = imm ? 2'b10 : 2'b00;
        SE_SIGN = imm && is_signed_imm(OP_CODE);
        WD_S    = is_cmp ? 2'b00 : 2'b11;
      end
      // WB serves ALU results, MOV and MOVI; the write-data select follows the class
      S_WB: begin
        REG_WR = 1'b1;
        if (cls == CLS_MOV)       WD_S = 2'b01;
        else if (cls == CLS_MOVI) WD_S = 2'b00;
        else                      WD_S = 2'b11;
      end
      S_MEMRD: MEM_REG_EN = mem_ready;
      S_LDWB: begin
        WD_S = 2'b10; REG_WR = 1'b1;
      end
      S_MEMWR: MEM_WE = 1'b1;
      S_BRANCH: begin
        if (taken) begin
          ALUA_S = 2'b01; ALUB_S = 2'b01; SE_SIGN = 1'b1;
          PC_S = 1'b1; PC_EN = 1'b1;
        end
      end
      S_JUMP: PC_EN = taken;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: an instruction-level model expands
// each instruction into its expected per-cycle control outputs.
module tb_cpu_controller;
  import cpu_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic pc_s, mem_data_s, se_sign, reg_wr, instr_en, alu_out_en, mem_reg_en, pc_en, psr_en, mem_we;
    logic [1:0] mem_s, wd_s, alua_s, alub_s;
    logic ill;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  mr;
  } step_t;

  logic clk, reset, mem_ready;
  logic [3:0] OP_CODE, OP_EXT, Rdest_addr;
  logic [4:0] PSR_OUT;
  logic PC_S, MEM_DATA_S, SE_SIGN, REG_WR, INSTR_EN, ALU_OUT_EN, MEM_REG_EN, PC_EN, PSR_EN, MEM_WE, illegal;
  logic [1:0] MEM_S, WD_S, ALUA_S, ALUB_S;
  logic [3:0] state;

  outs_t act, exp_o;
  logic  exp_valid;
  step_t q[$];
  int checks, errors;
  int n_reg_wr, n_psr_en, n_pc_en, n_mem_reg_en, n_mem_we, n_ill;

  cpu_controller dut (
    .clk(clk), .reset(reset), .OP_CODE(OP_CODE), .OP_EXT(OP_EXT), .Rdest_addr(Rdest_addr),
    .PSR_OUT(PSR_OUT), .mem_ready(mem_ready), .PC_S(PC_S), .MEM_DATA_S(MEM_DATA_S),
    .SE_SIGN(SE_SIGN), .REG_WR(REG_WR), .INSTR_EN(INSTR_EN), .ALU_OUT_EN(ALU_OUT_EN),
    .MEM_REG_EN(MEM_REG_EN), .PC_EN(PC_EN), .PSR_EN(PSR_EN), .MEM_WE(MEM_WE),
    .MEM_S(MEM_S), .WD_S(WD_S), .ALUA_S(ALUA_S), .ALUB_S(ALUB_S),
    .illegal(illegal), .state(state)
  );

  assign act = {state, PC_S, MEM_DATA_S, SE_SIGN, REG_WR, INSTR_EN, ALU_OUT_EN, MEM_REG_EN,
                PC_EN, PSR_EN, MEM_WE, MEM_S, WD_S, ALUA_S, ALUB_S, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL outs t=%0t actual=%h expected=%h", $time, act, exp_o);
      end
      if (REG_WR)     n_reg_wr++;
      if (PSR_EN)     n_psr_en++;
      if (PC_EN)      n_pc_en++;
      if (MEM_REG_EN) n_mem_reg_en++;
      if (MEM_WE)     n_mem_we++;
      if (illegal)    n_ill++;
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  function automatic outs_t blank(input logic [3:0] st);
    outs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  // condition truth from the flag table: codes 0..9 are flag / inverted flag pairs
  function automatic bit cond_true(input logic [3:0] c, input logic [4:0] p);
    logic [4:0] pick;
    bit n, z, f, l, cy;
    n = p[4]; z = p[3]; f = p[2]; l = p[1]; cy = p[0];
    pick = {f, n, l, cy, z};
    if (c < 4'd10) return c[0] ? !pick[c[3:1]] : pick[c[3:1]];
    case (c)
      4'd10:   return !l && !z;
      4'd11:   return l || z;
      4'd12:   return !n && !z;
      4'd13:   return n || z;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit alu_code(input logic [3:0] x);
    return x inside {4'b0101, 4'b1001, 4'b1011, 4'b0001, 4'b0010, 4'b0011};
  endfunction

  task automatic push(input outs_t o, input logic mr);
    step_t s;
    s.o = o;
    s.mr = mr;
    q.push_back(s);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic build(input logic [15:0] ins, input logic [4:0] psr, input int fw, input int mw);
    logic [3:0] op, rd, ext;
    outs_t o;
    bit imm, cmp;
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4];
    q.delete();
    for (int i = 0; i < fw; i++) begin
      o = blank(S_FETCH); o.mem_s = 2'b01; push(o, 1'b0);
    end
    o = blank(S_FETCH); o.mem_s = 2'b01; push(o, 1'b1);
    o = blank(S_FLOAD); o.instr_en = 1; o.alua_s = 2'b01; o.alub_s = 2'b10;
    o.pc_s = 1; o.pc_en = 1; push(o, rnd());
    if ((op == 4'd0 && alu_code(ext)) || (op != 4'd0 && alu_code(op))) begin
      imm = (op != 4'd0);
      cmp = imm ? (op == 4'd11) : (ext == 4'd11);
      o = blank(S_DECODE);
      o.alua_s = imm ? 2'b10 : 2'b00;
      o.se_sign = imm && (op inside {4'd5, 4'd9, 4'd11});
      push(o, rnd());
      o.st = S_EXEC; o.alu_out_en = 1; o.psr_en = 1; o.wd_s = cmp ? 2'b00 : 2'b11;
      push(o, rnd());
      if (!cmp) begin
        o = blank(S_WB); o.reg_wr = 1; o.wd_s = 2'b11; push(o, rnd());
      end
    end else if ((op == 4'd0 && ext == 4'd13) || op == 4'd13) begin
      o = blank(S_DECODE); o.wd_s = (op == 4'd0) ? 2'b01 : 2'b00; push(o, rnd());
      o.st = S_WB; o.reg_wr = 1; push(o, rnd());
    end else if (op == 4'd4 && ext == 4'd0) begin
      push(blank(S_DECODE), rnd());
      for (int i = 0; i < mw; i++) push(blank(S_MEMRD), 1'b0);
      o = blank(S_MEMRD); o.mem_reg_en = 1; push(o, 1'b1);
      o = blank(S_LDWB); o.wd_s = 2'b10; o.reg_wr = 1; push(o, rnd());
    end else if (op == 4'd4 && ext == 4'd4) begin
      push(blank(S_DECODE), rnd());
      o = blank(S_MEMWR); o.mem_we = 1;
      for (int i = 0; i < mw; i++) push(o, 1'b0);
      push(o, 1'b1);
    end else if ((op == 4'd4 && ext == 4'd12) || op == 4'd12) begin
      push(blank(S_DECODE), rnd());
      o = blank(op == 4'd12 ? S_BRANCH : S_JUMP);
      if (cond_true(rd, psr)) begin
        o.pc_en = 1;
        if (op == 4'd12) begin
          o.alua_s = 2'b01; o.alub_s = 2'b01; o.se_sign = 1; o.pc_s = 1;
        end
      end
      push(o, rnd());
    end else begin
      o = blank(S_DECODE); o.ill = 1; push(o, rnd());
    end
  endtask

  task automatic run_queue(input logic [15:0] ins, input logic [4:0] psr);
    OP_CODE = ins[15:12]; Rdest_addr = ins[11:8]; OP_EXT = ins[7:4]; PSR_OUT = psr;
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      exp_o = q[i].o;
      exp_valid = 1'b1;
      @(posedge clk); #1;
    end
    exp_valid = 1'b0;
  endtask

  task automatic run(input logic [15:0] ins, input logic [4:0] psr, input int fw, input int mw);
    build(ins, psr, fw, mw);
    run_queue(ins, psr);
  endtask

  int r0, p0, c0, m0, w0, i0;

  task automatic snap();
    r0 = n_reg_wr; p0 = n_psr_en; c0 = n_pc_en; m0 = n_mem_reg_en; w0 = n_mem_we; i0 = n_ill;
  endtask

  initial begin
    checks = 0; errors = 0; exp_valid = 1'b0;
    n_reg_wr = 0; n_psr_en = 0; n_pc_en = 0; n_mem_reg_en = 0; n_mem_we = 0; n_ill = 0;
    reset = 1'b0; mem_ready = 1'b0;
    OP_CODE = '0; OP_EXT = '0; Rdest_addr = '0; PSR_OUT = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_mem_s", MEM_S, 1);
    chk("rst_others", {PC_EN, REG_WR, MEM_WE, PSR_EN, INSTR_EN, illegal, WD_S, ALUA_S, ALUB_S}, 0);
    reset = 1'b1;

    snap(); build(16'h0251, 5'b0, 0, 0); chk("add_len", q.size(), 5); run_queue(16'h0251, 5'b0);
    chk("add_reg_wr", n_reg_wr - r0, 1); chk("add_psr_en", n_psr_en - p0, 1);
    run(16'h0391, 5'b0, 2, 0);
    run(16'h02B1, 5'b0, 0, 0);
    snap(); build(16'h4301, 5'b0, 0, 2); chk("load_len", q.size(), 7); run_queue(16'h4301, 5'b0);
    chk("load_mem_reg_en", n_mem_reg_en - m0, 1); chk("load_reg_wr", n_reg_wr - r0, 1);
    snap(); run(16'h4442, 5'b0, 1, 1); chk("stor_mem_we", n_mem_we - w0, 2);
    snap(); run(16'hC0FE, 5'b01000, 0, 0); chk("br_taken_pc_en", n_pc_en - c0, 2);
    snap(); build(16'hC0FE, 5'b0, 0, 0); chk("br_len", q.size(), 4); run_queue(16'hC0FE, 5'b0);
    chk("br_not_pc_en", n_pc_en - c0, 1);
    snap(); build(16'hB105, 5'b0, 0, 0); chk("cmpi_len", q.size(), 4); run_queue(16'hB105, 5'b0);
    chk("cmpi_reg_wr", n_reg_wr - r0, 0); chk("cmpi_psr_en", n_psr_en - p0, 1);
    run(16'h1207, 5'b0, 0, 0);
    run(16'h03D1, 5'b0, 0, 0);
    run(16'hD305, 5'b0, 1, 0);
    run(16'h4EC2, 5'b0, 0, 0);
    run(16'h4FC2, 5'b11111, 0, 0);
    run(16'hCA10, 5'b00010, 0, 0);
    run(16'hCD10, 5'b10000, 0, 0);
    run(16'hC301, 5'b00001, 0, 0);
    snap(); run(16'hF000, 5'b0, 0, 0);
    chk("ill_pulse", n_ill - i0, 1); chk("ill_reg_wr", n_reg_wr - r0, 0); chk("ill_mem_we", n_mem_we - w0, 0);
    run(16'h4712, 5'b0, 0, 0);

    // stall a store in MEMWR, then pull reset between clock edges
    build(16'h4442, 5'b0, 0, 3);
    void'(q.pop_back()); void'(q.pop_back());
    run_queue(16'h4442, 5'b0);
    mem_ready = 1'b0;
    #2;
    chk("memwr_we_hold", MEM_WE, 1);
    chk("memwr_state", state, S_MEMWR);
    reset = 1'b0;
    #1;
    chk("rst_async_we", MEM_WE, 0);
    chk("rst_async_state", state, S_FETCH);
    chk("rst_async_mem_s", MEM_S, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    snap(); run(16'h0251, 5'b0, 0, 0); chk("post_rst_reg_wr", n_reg_wr - r0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
